// File: rtl/rtc_bus_write_if.sv
// Bus-side handshake and pad signals between the field mux and the RTC write-cycle generator.
interface rtc_bus_write_if;
  logic       Start;
  logic [7:0] Addr;
  logic [7:0] Dato_in;
  logic [7:0] Bus_out;
  logic       Bus_oe;
  logic       A_D;
  logic       CS_n;
  logic       WR_n;
  logic       RD_n;
  logic       Busy;
  logic       Done;

  modport master (
    output Start, Addr, Dato_in,
    input  Bus_out, Bus_oe, A_D, CS_n, WR_n, RD_n, Busy, Done
  );

  modport slave (
    input  Start, Addr, Dato_in,
    output Bus_out, Bus_oe, A_D, CS_n, WR_n, RD_n, Busy, Done
  );
endinterface

// File: rtl/rtc_bus_write.sv
// Two-phase (address then data) write cycle generator for the RTC multiplexed AD bus.
// Outputs are registered from the current state, so pins lag the FSM by one cycle.
module rtc_bus_write #(
  parameter int PH_CYC = 4
) (
  input logic          Clock,
  input logic          Reset,
  rtc_bus_write_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_H, S_DATA, S_DATA_H, S_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] bus_out;
    logic       oe;
    logic       a_d;
    logic       cs_n;
    logic       wr_n;
    logic       busy;
    logic       done;
  } out_t;

  localparam logic [7:0] LAST   = 8'(PH_CYC - 1);
  localparam out_t       OUT_IDLE = '{bus_out: 8'h00, oe: 1'b0, a_d: 1'b0, cs_n: 1'b1,
                                      wr_n: 1'b1, busy: 1'b0, done: 1'b0};

  state_t     state_q, state_d;
  logic [7:0] cnt_q, addr_q, data_q;
  logic       ph_end;
  out_t       out_d, out_q;

  assign ph_end = (cnt_q == LAST);

  // State register, phase counter and captured operands
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'h00;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || state_q == S_IDLE) cnt_q <= 8'h00;
      else                                         cnt_q <= cnt_q + 8'd1;
      if (state_q == S_IDLE && bus.Start) begin
        addr_q <= bus.Addr;
        data_q <= bus.Dato_in;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.Start) state_d = S_ADDR;
      S_ADDR:   if (ph_end)    state_d = S_ADDR_H;
      S_ADDR_H: if (ph_end)    state_d = S_DATA;
      S_DATA:   if (ph_end)    state_d = S_DATA_H;
      S_DATA_H: if (ph_end)    state_d = S_DONE;
      S_DONE:                  state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_d = OUT_IDLE;
    case (state_q)
      S_ADDR:   out_d = '{bus_out: addr_q, oe: 1'b1, a_d: 1'b0, cs_n: 1'b0,
                          wr_n: 1'b0, busy: 1'b1, done: 1'b0};
      S_ADDR_H: out_d = '{bus_out: addr_q, oe: 1'b1, a_d: 1'b0, cs_n: 1'b1,
                          wr_n: 1'b1, busy: 1'b1, done: 1'b0};
      S_DATA:   out_d = '{bus_out: data_q, oe: 1'b1, a_d: 1'b1, cs_n: 1'b0,
                          wr_n: 1'b0, busy: 1'b1, done: 1'b0};
      S_DATA_H: out_d = '{bus_out: data_q, oe: 1'b1, a_d: 1'b1, cs_n: 1'b1,
                          wr_n: 1'b1, busy: 1'b1, done: 1'b0};
      S_DONE:   out_d = '{bus_out: 8'h00, oe: 1'b0, a_d: 1'b0, cs_n: 1'b1,
                          wr_n: 1'b1, busy: 1'b1, done: 1'b1};
      default:  out_d = OUT_IDLE;
    endcase
  end

  // Pin register; reset forces the bus released and strobes inactive at once
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) out_q <= OUT_IDLE;
    else       out_q <= out_d;
  end

  assign bus.Bus_out = out_q.bus_out;
  assign bus.Bus_oe  = out_q.oe;
  assign bus.A_D     = out_q.a_d;
  assign bus.CS_n    = out_q.cs_n;
  assign bus.WR_n    = out_q.wr_n;
  assign bus.RD_n    = 1'b1;
  assign bus.Busy    = out_q.busy;
  assign bus.Done    = out_q.done;

endmodule

// File: doc/rtc_bus_write.md
# rtc_bus_write

Write-cycle generator for the external RTC's multiplexed address/data bus. It takes one register address and one 8-bit BCD value, such as the packed BCD produced by the binary-to-BCD decoders for year, month, day, hour and similar fields. It then runs a complete two-phase Intel-style write: an address phase followed by a data phase. It sits between the BCD decoders/field mux and the bidirectional bus pad logic.

## Interface
Parameters:
- PH_CYC, default 4: clock cycles per bus phase; legal range 1..255.

Ports:
- Clock  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  request a write; sampled only in IDLE.
- Addr  in  8  RTC register address; captured on Start acceptance.
- Dato_in  in  8  BCD data; captured on Start acceptance; not range-checked.
- Bus_out  out  8  value to drive onto the AD bus.
- Bus_oe  out  1  pad output enable; 1 means the bus is driven.
- A_D  out  1  address/data select; 0 for address phase, 1 for data phase.
- CS_n  out  1  chip select, active low.
- WR_n  out  1  write strobe, active low.
- RD_n  out  1  read strobe; held at 1 because this block only writes.
- Busy  out  1  transaction in progress.
- Done  out  1  one-cycle pulse when the transaction completes.

## Operation
- All outputs are registered.
- The block has one FSM and an 8-bit phase counter.
- The FSM states, with their transitions and output values, are:
  - IDLE:
    - Outputs: CS_n=1, WR_n=1, Bus_oe=0, A_D=0, Bus_out=0x00, Busy=0, Done=0.
    - Start=1 captures Addr and Dato_in into internal registers and moves to ADDR.
  - ADDR, lasting PH_CYC cycles:
    - Outputs: Bus_out=addr_q, Bus_oe=1, A_D=0, CS_n=0, WR_n=0, Busy=1.
  - ADDR_H, lasting PH_CYC cycles:
    - Outputs: Bus_out=addr_q, Bus_oe=1, A_D=0, CS_n=1, WR_n=1, Busy=1.
    - The address is held after the strobe rises.
  - DATA, lasting PH_CYC cycles:
    - Outputs: Bus_out=data_q, Bus_oe=1, A_D=1, CS_n=0, WR_n=0, Busy=1.
  - DATA_H, lasting PH_CYC cycles:
    - Outputs: Bus_out=data_q, Bus_oe=1, A_D=1, CS_n=1, WR_n=1, Busy=1.
  - DONE, lasting 1 cycle:
    - Outputs: Done=1, Busy=1, Bus_oe=0, CS_n=1, WR_n=1, A_D=0, Bus_out=0x00.
    - Next state is always IDLE.
- Phase counter:
  - Loads 0 on entry to each timed state.
  - Increments each cycle.
  - The state advances when count == PH_CYC-1.
- Start outside IDLE is ignored; the block has no queue.
- Changes on Addr or Dato_in after acceptance have no effect on the bus.
- RD_n is constant 1 in all states, including during reset.

## Timing
- Reset, asynchronous:
  - All outputs take their IDLE values immediately, including CS_n=1, WR_n=1, RD_n=1, Bus_oe=0, Busy=0 and Done=0.
  - FSM goes to IDLE, counter to 0, addr_q and data_q to 0x00.
- Reset mid-transaction: the write is aborted without completion and Done does not pulse. After Reset deasserts, the block waits in IDLE for a new Start.
- Let the Start-accept edge be edge 0 and P = PH_CYC. Outputs are valid after each listed edge:
  - ADDR: edges 1..P.
  - ADDR_H: edges P+1..2P.
  - DATA: edges 2P+1..3P.
  - DATA_H: edges 3P+1..4P.
  - DONE: edge 4P+1.
  - IDLE: edge 4P+2.
- WR_n low width is exactly P cycles per phase, and each CS_n low window is exactly P cycles.
- Bus_oe stays high continuously for 4P cycles; the bus is never released between the address and data phases.
- Back-to-back writes: with Start held at 1, the next acceptance occurs in the IDLE cycle after DONE. Spacing between successive ADDR entries is 4P+2 cycles.
- Start coinciding with DONE is ignored. It is accepted in the following IDLE cycle only if it is still asserted there.

## Test plan
- PH_CYC=4, Start pulse with Addr=0x26, Dato_in=0x99 -> Bus_out=0x26 with A_D=0:
  - WR_n low cycles 1-4; address held cycles 5-8.
  - Bus_out=0x99 with A_D=1; WR_n low cycles 9-12; data held cycles 13-16.
  - Done=1 at cycle 17; Busy=0 at cycle 18.
- Start re-pulsed at cycle 6 with Addr=0x10, Dato_in=0x05 -> ignored; the bus shows 0x26 then 0x99 only, and exactly one Done pulse occurs.
- Reset asserted asynchronously mid-cycle at cycle 10, during the DATA phase -> same instant: CS_n=1, WR_n=1, Bus_oe=0, Busy=0. There is no Done pulse, and the block is in IDLE after release.
- PH_CYC=1, Addr=0x24, Dato_in=0x59 -> ADDR, ADDR_H, DATA and DATA_H each last 1 cycle; Done at cycle 5.
- Start held high, PH_CYC=2, Addr=0x21, Dato_in=0x12 -> repeated writes with ADDR entries at cycles 1, 11 and 21. Each Done is a single cycle, and RD_n is never 0.
- Dato_in changed from 0x07 to 0x08 at cycle 1 after acceptance -> the data phase drives 0x07.
